// File: rtl/f_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : f_arb_pkg
// Description : Shared types and constants for the dense-polynomial RAM
//               port-A arbiter (state enum, default requester count,
//               index-width helper).
// Revision    : 1.0 - initial release
// ============================================================================
package f_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } arb_state_t;

  localparam int C_DEF_NUM_REQ = 3;

  // Width of a requester index; never below one bit.
  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/f_port_arb_if.sv
`default_nettype none
// ============================================================================
// Module      : f_port_arb_if
// Description : Bus bundle between the port-A requesters / RAM and the
//               arbiter. Optional macro F_PORT_ARB_TIMEOUT_EN adds the
//               sticky timeout flag.
// Ports       : req/rel/req_we      per-requester request, release, write en
//               req_addr/req_dout   flattened per-requester address / data
//               gnt/owner/busy      grant state
//               f_addra/f_wea/f_douta/f_dina  RAM port A
//               rdata               read data broadcast
//               err/timeout         sticky status flags
// Revision    : 1.0 - initial release
// ============================================================================
interface f_port_arb_if import f_arb_pkg::*; #(
  parameter int NUM_REQ  = C_DEF_NUM_REQ,
  parameter int G_ADDR_W = 8,
  parameter int G_DAT_W  = 64
) ();

  localparam int IDX_W = idx_w(NUM_REQ);

  logic [NUM_REQ-1:0]          req;
  logic [NUM_REQ-1:0]          rel;
  logic [NUM_REQ*G_ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0]          req_we;
  logic [NUM_REQ*G_DAT_W-1:0]  req_dout;
  logic [NUM_REQ-1:0]          gnt;
  logic [IDX_W-1:0]            owner;
  logic                        busy;
  logic [G_ADDR_W-1:0]         f_addra;
  logic                        f_wea;
  logic [G_DAT_W-1:0]          f_douta;
  logic [G_DAT_W-1:0]          f_dina;
  logic [G_DAT_W-1:0]          rdata;
  logic                        err;
`ifdef F_PORT_ARB_TIMEOUT_EN
  logic                        timeout;
`endif

  modport master (
    output req, rel, req_addr, req_we, req_dout, f_dina,
    input  gnt, owner, busy, f_addra, f_wea, f_douta, rdata, err
`ifdef F_PORT_ARB_TIMEOUT_EN
    , input timeout
`endif
  );

  modport slave (
    input  req, rel, req_addr, req_we, req_dout, f_dina,
    output gnt, owner, busy, f_addra, f_wea, f_douta, rdata, err
`ifdef F_PORT_ARB_TIMEOUT_EN
    , output timeout
`endif
  );

endinterface
`default_nettype wire

// File: rtl/f_port_arb_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker. Searches upward from
//               i_ptr+1 (mod NUM_REQ) for the first set request bit.
// Ports       : i_req     request vector
//               i_ptr     index of the last winner
//               o_onehot  one-hot winner
//               o_idx     winner index
//               o_any     at least one request present
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_onehot,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_any
);

  // Doubling the vector and shifting right by ptr+1 rotates the search
  // start to bit 0, so the scan below uses only constant bit indices.
  logic [2*NUM_REQ-1:0] w_rot;
  int                   w_win;

  always_comb begin
    w_rot    = {i_req, i_req} >> (int'(i_ptr) + 1);
    w_win    = 0;
    o_any    = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!o_any && w_rot[k]) begin
        o_any = 1'b1;
        w_win = int'(i_ptr) + 1 + k;
      end
    end
    if (w_win >= NUM_REQ) begin
      w_win = w_win - NUM_REQ;
    end
    o_idx    = IDX_W'(w_win);
    o_onehot = o_any ? (NUM_REQ'(1) << w_win) : '0;
  end

endmodule
`default_nettype wire

// File: rtl/f_port_arb.sv
`default_nettype none
// ============================================================================
// Module      : f_port_arb
// Description : Round-robin owner arbiter for RAM port A. Grants the port
//               to one requester at a time, holds ownership until release,
//               muxes the owner's bus onto the RAM and inserts a one-cycle
//               RELEASE gap between owners.
//               Optional macro F_PORT_ARB_TIMEOUT_EN: grants longer than
//               MAX_HOLD cycles are revoked and flagged on bus.timeout.
// Ports       : clk   system clock
//               rst   synchronous active-high reset
//               bus   f_port_arb_if.slave (requester buses, RAM port A,
//                     grant/owner/busy, err, optional timeout)
// Revision    : 1.0 - initial release
// ============================================================================
module f_port_arb import f_arb_pkg::*; #(
  parameter int NUM_REQ  = C_DEF_NUM_REQ,
  parameter int G_ADDR_W = 8,
  parameter int G_DAT_W  = 64,
  parameter int MAX_HOLD = 1024
) (
  input  logic         clk,
  input  logic         rst,
  f_port_arb_if.slave  bus
);

  localparam int IDX_W = idx_w(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || MAX_HOLD < 2) begin : g_param_chk
    $error("f_port_arb: parameter out of range");
  end

  arb_state_t           r_state, w_state_nxt;
  logic [NUM_REQ-1:0]   r_gnt;
  logic [IDX_W-1:0]     r_owner;
  logic [IDX_W-1:0]     r_ptr;
  logic                 r_err;

  logic [NUM_REQ-1:0]   w_pick_oh;
  logic [IDX_W-1:0]     w_pick_idx;
  logic                 w_pick_any;
  logic                 w_own_rel;
  logic                 w_own_drop;
  logic                 w_expire;
  logic                 w_release;
  logic                 w_proto_err;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .i_req    (bus.req),
    .i_ptr    (r_ptr),
    .o_onehot (w_pick_oh),
    .o_idx    (w_pick_idx),
    .o_any    (w_pick_any)
  );

  // r_gnt is one-hot on the owner while in GRANT, so masking with it
  // selects the owner's own rel/req without a dynamic index.
  assign w_own_rel   = |(bus.rel & r_gnt);
  assign w_own_drop  = |(~bus.req & r_gnt);
  assign w_release   = (r_state == ST_GRANT) && (w_own_rel || w_own_drop || w_expire);
  assign w_proto_err = |(bus.rel & ~r_gnt) || |(bus.req_we & ~r_gnt);

`ifdef F_PORT_ARB_TIMEOUT_EN
  localparam int HOLD_W = $clog2(MAX_HOLD);

  logic [HOLD_W-1:0] r_hold;
  logic              r_timeout;

  assign w_expire = (r_state == ST_GRANT) && (r_hold == HOLD_W'(MAX_HOLD - 1));

  // GRANT is only ever entered from IDLE, so clearing throughout IDLE is
  // the same as clearing on entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold    <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (r_state == ST_GRANT) begin
        r_hold <= r_hold + 1'b1;
      end else begin
        r_hold <= '0;
      end
      if (w_expire && !w_own_rel && !w_own_drop) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign bus.timeout = r_timeout;
`else
  assign w_expire = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (w_pick_any) w_state_nxt = ST_GRANT;
      ST_GRANT:   if (w_release)  w_state_nxt = ST_RELEASE;
      ST_RELEASE: w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_gnt   <= '0;
      r_owner <= '0;
      r_ptr   <= IDX_W'(NUM_REQ - 1);
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_proto_err) begin
        r_err <= 1'b1;
      end
      if (r_state == ST_IDLE && w_pick_any) begin
        r_gnt   <= w_pick_oh;
        r_owner <= w_pick_idx;
        r_ptr   <= w_pick_idx;
      end else if (w_release) begin
        r_gnt   <= '0;
      end
    end
  end

  // One-hot AND-OR mux on the registered grant; gnt is zero outside GRANT,
  // which forces the RAM bus to zero in IDLE and RELEASE.
  logic [G_ADDR_W-1:0] w_addra;
  logic                w_wea;
  logic [G_DAT_W-1:0]  w_douta;

  always_comb begin
    w_addra = '0;
    w_wea   = 1'b0;
    w_douta = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_gnt[i]) begin
        w_addra = bus.req_addr[i*G_ADDR_W +: G_ADDR_W];
        w_wea   = bus.req_we[i];
        w_douta = bus.req_dout[i*G_DAT_W +: G_DAT_W];
      end
    end
  end

  assign bus.f_addra = w_addra;
  assign bus.f_wea   = w_wea;
  assign bus.f_douta = w_douta;
  assign bus.gnt     = r_gnt;
  assign bus.owner   = r_owner;
  assign bus.busy    = (r_state != ST_IDLE);
  assign bus.rdata   = bus.f_dina;
  assign bus.err     = r_err;

endmodule
`default_nettype wire

// File: tb/tb_f_port_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_f_port_arb
// Description : Self-checking bench for f_port_arb. Directed scenarios and
//               a randomized run are compared every cycle against a
//               behavioural ownership model. Timeout scenario runs when
//               F_PORT_ARB_TIMEOUT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_f_port_arb;

  localparam int C_NUM_REQ  = 3;
  localparam int C_AW       = 8;
  localparam int C_DW       = 64;
  localparam int C_MAX_HOLD = 16;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  f_port_arb_if #(.NUM_REQ(C_NUM_REQ), .G_ADDR_W(C_AW), .G_DAT_W(C_DW)) bus ();

  f_port_arb #(
    .NUM_REQ  (C_NUM_REQ),
    .G_ADDR_W (C_AW),
    .G_DAT_W  (C_DW),
    .MAX_HOLD (C_MAX_HOLD)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: who owns the port (-1 none), whether the mandatory
  // one-cycle gap is pending, round-robin pointer, last winner, flags.
  int m_own, m_gap, m_ptr, m_last, m_hold;
  bit m_err, m_to;

  logic [C_NUM_REQ-1:0]      r_tb_req;
  logic [C_NUM_REQ*C_AW-1:0] c_addr = {8'h3F, 8'h22, 8'h11};
  logic [C_NUM_REQ*C_DW-1:0] c_data = {64'hCCCC_0000_2222_0002,
                                       64'hBBBB_0000_1111_0001,
                                       64'hAAAA_0000_0000_0000};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_own  = -1;
    m_gap  = 0;
    m_ptr  = C_NUM_REQ - 1;
    m_last = 0;
    m_hold = 0;
    m_err  = 1'b0;
    m_to   = 1'b0;
  endtask

  task automatic model_update(input logic r, input logic [2:0] rq,
                              input logic [2:0] rl, input logic [2:0] we);
    if (r) begin
      model_reset();
    end else begin
      for (int i = 0; i < C_NUM_REQ; i++) begin
        if (i != m_own && (rl[i] || we[i])) m_err = 1'b1;
      end
      if (m_own >= 0) begin
        bit expire;
        expire = 1'b0;
`ifdef F_PORT_ARB_TIMEOUT_EN
        expire = (m_hold + 1 >= C_MAX_HOLD);
`endif
        if (rl[m_own] || !rq[m_own] || expire) begin
          if (expire && !rl[m_own] && rq[m_own]) m_to = 1'b1;
          m_own = -1;
          m_gap = 1;
        end else begin
          m_hold++;
        end
      end else if (m_gap != 0) begin
        m_gap = 0;
      end else begin
        for (int k = 1; k <= C_NUM_REQ; k++) begin
          int c;
          c = (m_ptr + k) % C_NUM_REQ;
          if (rq[c]) begin
            m_own  = c;
            m_last = c;
            m_ptr  = c;
            m_hold = 0;
            break;
          end
        end
      end
    end
  endtask

  // One clock cycle: drive on the falling edge, check 1 ns later, then let
  // the rising edge happen and advance the model with the same inputs.
  task automatic step(input logic r, input logic [2:0] rq, input logic [2:0] rl,
                      input logic [2:0] we, input logic [23:0] ad,
                      input logic [191:0] dt, input logic [63:0] din);
    logic [2:0] e_gnt;
    @(negedge clk);
    rst          = r;
    bus.req      = rq;
    bus.rel      = rl;
    bus.req_we   = we;
    bus.req_addr = ad;
    bus.req_dout = dt;
    bus.f_dina   = din;
    #1;
    e_gnt = '0;
    if (m_own >= 0) e_gnt[m_own] = 1'b1;
    chk("gnt",     64'(bus.gnt),   64'(e_gnt));
    chk("owner",   64'(bus.owner), 64'(m_last));
    chk("busy",    64'(bus.busy),  64'((m_own >= 0) || (m_gap != 0)));
    chk("f_addra", 64'(bus.f_addra), (m_own >= 0) ? 64'(ad[m_own*C_AW +: C_AW]) : 64'd0);
    chk("f_wea",   64'(bus.f_wea),   (m_own >= 0) ? 64'(we[m_own]) : 64'd0);
    chk("f_douta", bus.f_douta,      (m_own >= 0) ? dt[m_own*C_DW +: C_DW] : 64'd0);
    chk("rdata",   bus.rdata, din);
    chk("err",     64'(bus.err), 64'(m_err));
`ifdef F_PORT_ARB_TIMEOUT_EN
    chk("timeout", 64'(bus.timeout), 64'(m_to));
`endif
    @(posedge clk);
    model_update(r, rq, rl, we);
  endtask

  // Owner releases on its hold_len-th grant cycle (0 = never); the owner
  // always writes; rogue_we adds writes from other requesters.
  task automatic run_rule(input int n, input logic [2:0] rq, input int hold_len,
                          input logic [2:0] rogue_we);
    for (int c = 0; c < n; c++) begin
      logic [2:0] rl, we;
      rl = '0;
      we = rogue_we;
      if (m_own >= 0) begin
        we[m_own] = 1'b1;
        if (hold_len > 0 && m_hold == hold_len - 1) rl[m_own] = 1'b1;
      end
      step(1'b0, rq, rl, we, c_addr, c_data, {$urandom, $urandom});
    end
  endtask

  task automatic rand_cycle();
    logic       r;
    logic [2:0] rl, we;
    r  = ($urandom_range(0, 199) == 0);
    rl = '0;
    we = '0;
    for (int i = 0; i < C_NUM_REQ; i++) begin
      if (m_own == i) begin
        int x;
        x = int'($urandom_range(0, 23));
        if (x == 0)      r_tb_req[i] = 1'b0;
        else if (x == 1) rl[i] = 1'b1;
        we[i] = 1'($urandom_range(0, 1));
      end else if (!r_tb_req[i]) begin
        if ($urandom_range(0, 3) == 0) r_tb_req[i] = 1'b1;
      end else if ($urandom_range(0, 39) == 0) begin
        r_tb_req[i] = 1'b0;
      end
    end
    if ($urandom_range(0, 249) == 0) begin
      int v;
      v = int'($urandom_range(0, C_NUM_REQ - 1));
      if (v != m_own) begin
        if ($urandom_range(0, 1) == 1) rl[v] = 1'b1;
        else                           we[v] = 1'b1;
      end
    end
    step(r, r_tb_req, rl, we, 24'($urandom),
         {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
         {$urandom, $urandom});
  endtask

  initial begin
    rst          = 1'b1;
    bus.req      = '0;
    bus.rel      = '0;
    bus.req_we   = '0;
    bus.req_addr = '0;
    bus.req_dout = '0;
    bus.f_dina   = '0;
    r_tb_req     = '0;
    model_reset();
    repeat (2) @(posedge clk);

    // Reset state
    step(1'b1, 3'b000, 3'b000, 3'b000, c_addr, c_data, 64'h1234);

    // Single request from requester 1, release on 5th grant cycle, then idle
    run_rule(7, 3'b010, 5, 3'b000);
    run_rule(4, 3'b000, 0, 3'b000);

    // Round robin with all three requesting, 4-cycle holds
    step(1'b1, 3'b000, 3'b000, 3'b000, c_addr, c_data, 64'h0);
    run_rule(40, 3'b111, 4, 3'b000);

    // Write isolation: requester 2 writes to 0x3F while 0 owns the port
    step(1'b1, 3'b000, 3'b000, 3'b000, c_addr, c_data, 64'h0);
    run_rule(8, 3'b001, 0, 3'b100);

    // Owner 1 releases while still requesting; requester 2 gets it next
    step(1'b1, 3'b000, 3'b000, 3'b000, c_addr, c_data, 64'h0);
    run_rule(20, 3'b110, 3, 3'b000);

    // Reset while requester 0 writes, then it wins first again
    step(1'b1, 3'b000, 3'b000, 3'b000, c_addr, c_data, 64'h0);
    run_rule(4, 3'b001, 0, 3'b000);
    step(1'b1, 3'b001, 3'b000, 3'b001, c_addr, c_data, 64'h0);
    run_rule(4, 3'b011, 0, 3'b000);

`ifdef F_PORT_ARB_TIMEOUT_EN
    // Requester 1 never releases, requester 2 waits
    step(1'b1, 3'b000, 3'b000, 3'b000, c_addr, c_data, 64'h0);
    run_rule(2, 3'b010, 0, 3'b000);
    run_rule(24, 3'b110, 0, 3'b000);
`endif

    // Randomized run
    step(1'b1, 3'b000, 3'b000, 3'b000, c_addr, c_data, 64'h0);
    r_tb_req = '0;
    for (int c = 0; c < 4000; c++) begin
      rand_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
